// File: rtl/tia_clk_burst_gen.sv
// Burst clock generator: gated TIA clock, per-period sample strobe and burst status.
// Optional macro TIA_CLK_BURST_CONTINUOUS_EN: pulse_count = 0 runs until stop or reset.
module tia_clk_burst_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic [CNT_WIDTH-1:0] pulse_count,
  output logic                 tia_clk,
  output logic                 sample_stb,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] pulses_done
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_hp;
  logic [DIV_WIDTH-1:0] r_div;
  logic [CNT_WIDTH-1:0] r_n;
  logic [CNT_WIDTH-1:0] r_pd;
  logic                 r_tia, r_stb, r_busy, r_done, r_aborted;

  logic [DIV_WIDTH-1:0] w_hp;
  logic                 w_phase_end;
  logic                 w_burst_end;
  logic                 w_empty;

  assign w_hp        = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
  assign w_phase_end = (r_div == r_hp);
  // r_n == 0 only survives into a burst in continuous mode, where it never terminates
  assign w_burst_end = (r_n != '0) && (r_pd == r_n);

`ifdef TIA_CLK_BURST_CONTINUOUS_EN
  assign w_empty = 1'b0;
`else
  assign w_empty = (pulse_count == '0);
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_hp      <= '0;
      r_div     <= '0;
      r_n       <= '0;
      r_pd      <= '0;
      r_tia     <= 1'b0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // stop beats a simultaneous start and leaves status untouched
          if (start && !stop) begin
            r_hp      <= w_hp;
            r_n       <= pulse_count;
            r_div     <= DIV_WIDTH'(1);
            r_aborted <= 1'b0;
            if (w_empty) begin
              r_pd   <= '0;
              r_done <= 1'b1;
            end else begin
              r_pd    <= CNT_WIDTH'(1);
              r_done  <= 1'b0;
              r_tia   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_HIGH;
            end
          end
        end
        S_HIGH, S_LOW: begin
          if (stop) begin
            r_state   <= S_IDLE;
            r_tia     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (!w_phase_end) begin
            r_div <= r_div + DIV_WIDTH'(1);
          end else if (r_state == S_HIGH) begin
            r_state <= S_LOW;
            r_tia   <= 1'b0;
            r_stb   <= 1'b1;
            r_div   <= DIV_WIDTH'(1);
          end else if (w_burst_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_HIGH;
            r_tia   <= 1'b1;
            r_pd    <= r_pd + CNT_WIDTH'(1);
            r_div   <= DIV_WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tia_clk     = r_tia;
  assign sample_stb  = r_stb;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign pulses_done = r_pd;

endmodule

// File: tb/tb_tia_clk_burst_gen.sv
// Scoreboard bench: per-cycle expected outputs are queued from closed-form timing, then popped each cycle.
module tb_tia_clk_burst_gen;

  logic        ACLK = 1'b0;
  logic        ARESET, start, stop;
  logic [15:0] half_period, pulse_count;
  logic        tia_clk, sample_stb, busy, done, aborted;
  logic [15:0] pulses_done;

  tia_clk_burst_gen #(.DIV_WIDTH(16), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .stop(stop),
    .half_period(half_period), .pulse_count(pulse_count),
    .tia_clk(tia_clk), .sample_stb(sample_stb), .busy(busy), .done(done),
    .aborted(aborted), .pulses_done(pulses_done)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        tia, stb, busy, done, ab;
    logic [15:0] pd;
  } exp_t;

  exp_t q[$];
  exp_t e, got;
  int   total = 0, bad = 0, k;

  // Cycle c (1-based) of a burst started at cycle 0; n = 0 means endless.
  function automatic exp_t exp_at(int hp, int n, int c);
    exp_t r;
    int   ph;
    r = '0;
    if (n == 0 || c <= 2 * hp * n) begin
      ph     = (c - 1) % (2 * hp);
      r.tia  = (ph < hp);
      r.stb  = (ph == hp);
      r.busy = 1'b1;
      r.pd   = 16'((c - 1) / (2 * hp) + 1);
    end else begin
      r.done = 1'b1;
      r.pd   = 16'(n);
    end
    return r;
  endfunction

  function automatic exp_t idle_st(logic d, logic a, int pd);
    exp_t r;
    r      = '0;
    r.done = d;
    r.ab   = a;
    r.pd   = 16'(pd);
    return r;
  endfunction

  task automatic kick(int hp, int n);
    half_period = 16'(hp);
    pulse_count = 16'(n);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    k = 0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; start = 1'b1; stop = 1'b0;
    half_period = 16'd2; pulse_count = 16'd3;
    q.push_back(idle_st(0, 0, 0));
    q.push_back(idle_st(0, 0, 0));
    @(posedge ACLK); #1;
    k = 0;
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 2) begin ARESET = 1'b0; start = 1'b0; end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_normal;
    for (int c = 1; c <= 14; c++) q.push_back(exp_at(2, 3, c));
    kick(2, 3);
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL normal cyc=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_hp_zero;
    for (int c = 1; c <= 6; c++) q.push_back(exp_at(1, 2, c));
    kick(0, 2);
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL hp_zero cyc=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_abort_collision;
    for (int c = 1; c <= 9; c++) q.push_back(exp_at(4, 10, c));
    for (int c = 10; c <= 15; c++) q.push_back(idle_st(1, 1, 2));
    kick(4, 10);
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 9) stop = 1'b1;
      else if (k == 12) begin start = 1'b1; stop = 1'b1; end
      else begin start = 1'b0; stop = 1'b0; end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 1; c <= 15; c++) q.push_back(exp_at(3, 2, c));
    kick(3, 2);
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL busy_start cyc=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 4) begin start = 1'b1; half_period = 16'd7; pulse_count = 16'd9; end
      else start = 1'b0;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 1; c <= 5; c++) q.push_back(exp_at(2, 5, c));
    q.push_back(idle_st(0, 0, 0));
    q.push_back(idle_st(0, 0, 0));
    for (int c = 8; c <= 29; c++) q.push_back(exp_at(2, 5, c - 7));
    kick(2, 5);
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, got, e);
      end
      ARESET = (k == 5);
      start  = (k == 7);
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_n_zero;
`ifdef TIA_CLK_BURST_CONTINUOUS_EN
    for (int c = 1; c <= 210; c++) q.push_back(exp_at(1, 0, c));
    for (int c = 211; c <= 213; c++) q.push_back(idle_st(1, 1, 105));
    kick(1, 0);
`else
    for (int c = 1; c <= 4; c++) q.push_back(idle_st(1, 0, 0));
    kick(3, 0);
`endif
    while (q.size() > 0) begin
      k++;
      e = q.pop_front();
      got = {tia_clk, sample_stb, busy, done, aborted, pulses_done};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL n_zero cyc=%0d got=%h exp=%h", k, got, e);
      end
      stop = (k == 210);
      @(posedge ACLK); #1;
    end
  endtask

  initial begin
    ARESET = 1'b0; start = 1'b0; stop = 1'b0;
    half_period = '0; pulse_count = '0;
    @(posedge ACLK); #1;
    test_reset;
    test_normal;
    test_hp_zero;
    test_abort_collision;
    test_back_to_back;
    test_reset_mid;
    test_n_zero;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
